decode_stage: RTL
=================

# decode_stage

Registered instruction-decode stage for the RV32I core, the pipelined successor to the combinational control decoder. It accepts an instruction and its PC over a valid/ready handshake, decodes the control bundle, register indices and sign-extended immediate, and presents them registered through a 2-entry skid buffer. It sits between fetch and the register file / ALU, supports pipeline flush and flags illegal encodings. RV32M decode is optional.

## Interface
- PC_W, 32, width of in_pc/out_pc
- ALUCTR_W, 5, ALUCtr width; must be ≥5
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; registered
- in_inst  in  32  instruction word
- in_pc  in  PC_W  PC of in_inst
- flush  in  1  discard all held entries
- out_valid  out  1  decoded entry available
- out_ready  in  1  consumer accepts entry
- out_pc  out  PC_W; out_rs1/out_rs2/out_rd  out  5 each; out_imm  out  32
- ExtOp 3, RegWr 1, ALUASrc 1, ALUBSrc 2, ALUCtr ALUCTR_W, Branch 3, MemtoReg 1, MemWr 1, MemOp 3, JumpS 1  out  decoded control
- out_illegal  out  1  entry is an illegal encoding

## Operation
- Decode: ExtOp I=000 S=001 B=010 J=011 U=100. ALUBSrc 00 none, 01 imm, 10 rs2. ALUCtr add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9, passB 10.
- R/I-ALU: as ALUCtr map, RegWr=1; B-type: ALUCtr=sub, ALUBSrc=10, Branch beq 001, bne 010, blt 011, bge 100, bltu 101, bgeu 110.
- Load: RegWr, MemtoReg, ALUBSrc=01, MemOp=func3. Store: MemWr, ExtOp=001, MemOp=func3.
- JAL: Branch=111, JumpS=1, ALUASrc=1, ExtOp=011. JALR: Branch=111, JumpS=0, ALUBSrc=01.
- AUIPC: ALUASrc=1 (PC), ALUBSrc=01, add. LUI: ALUBSrc=01, ALUCtr=passB. Both use ExtOp=100.
- Illegal if any of: inst[1:0]≠11; unknown opcode; R-type func7 not 0000000/0100000, or 0100000 with func3∉{000,101}; slli func7≠0; srli/srai func7 not 0000000/0100000; load func3∈{011,110,111}; store func3>010; branch func3∈{010,011}; jalr func3≠000.
- Illegal entries: out_illegal=1, RegWr=MemWr=MemtoReg=0, Branch=000; the entry still flows through the buffer.
- Skid buffer states: EMPTY, ONE (output register full), TWO (output + skid full).
  - EMPTY→ONE on accept.
  - ONE→ONE on accept + drain; ONE→TWO on accept without drain; ONE→EMPTY on drain without accept.
  - TWO→ONE on drain; skid moves to output.
- Ordering is strictly FIFO.
- flush: next state EMPTY; the in_valid of the same cycle is dropped; flush wins over simultaneous accept and drain.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is visible on outputs after N when the stage was EMPTY, or ONE and draining.
- Throughput 1/cycle with out_ready held high.
- in_ready is a register: in_ready = (next state ≠ TWO). It never depends combinationally on out_ready.
- Accept = in_valid & in_ready; drain = out_valid & out_ready. out_valid = (state ≠ EMPTY).
- Outputs stay stable while out_valid & !out_ready.
- Reset, including mid-transfer: state EMPTY, out_valid=0, in_ready=1. All data/control outputs are 0, out_illegal=0. Held entries are lost.

## Configuration
- RV32M_EN defined: func7=0000001 R-type decodes to mul 16, mulh 17, mulhsu 18, mulhu 19, div 20, divu 21, rem 22, remu 23, with RegWr=1 and ALUBSrc=10.
- RV32M_EN undefined: these encodings are illegal.

## Structure
- decode_pkg: opcode constants, ExtOp/ALUBSrc/ALUCtr/Branch encodings, skid state enum.
- One sub-module, decode_logic: combinational inst→control/imm/illegal. It is instantiated once, on the input side. The top holds the skid buffer and state machine.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, rd=1, RegWr=1, ALUBSrc=01, ALUCtr=0, imm=0x00000005.
- beq x0,x0,-4 (0xFE000EE3) → Branch=001, ExtOp=010, ALUCtr=1, imm=0xFFFFFFFC.
- out_ready=0, push 3 back-to-back → in_ready drops after 2 accepts and the third is held. Then out_ready=1 → order 1,2,3 with no loss or duplication.
- State TWO, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered instruction is dropped.
- mul x2,x1,x2 (0x02208133) → with RV32M_EN: ALUCtr=16, RegWr=1. Without: out_illegal=1, RegWr=0. 0x00000000 → out_illegal=1 in both builds.
- rst asserted asynchronously mid-cycle while in TWO → outputs 0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage.
// RV32M_EN (consumed by decode_logic) enables RV32M decode.
package decode_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] EXT_I = 3'b000;
   localparam logic [2:0] EXT_S = 3'b001;
   localparam logic [2:0] EXT_B = 3'b010;
   localparam logic [2:0] EXT_J = 3'b011;
   localparam logic [2:0] EXT_U = 3'b100;

   localparam logic [1:0] BSRC_NONE = 2'b00;
   localparam logic [1:0] BSRC_IMM  = 2'b01;
   localparam logic [1:0] BSRC_RS2  = 2'b10;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_SLL   = 5'd2;
   localparam logic [4:0] ALU_SLT   = 5'd3;
   localparam logic [4:0] ALU_SLTU  = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_OR    = 5'd8;
   localparam logic [4:0] ALU_AND   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_LT   = 3'b011;
   localparam logic [2:0] BR_GE   = 3'b100;
   localparam logic [2:0] BR_LTU  = 3'b101;
   localparam logic [2:0] BR_GEU  = 3'b110;
   localparam logic [2:0] BR_JMP  = 3'b111;

   typedef logic [1:0] skid_st_t;
   localparam skid_st_t ST_EMPTY = 2'd0;
   localparam skid_st_t ST_ONE   = 2'd1;
   localparam skid_st_t ST_TWO   = 2'd2;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [2:0]  extop;
      logic        regwr;
      logic        aluasrc;
      logic [1:0]  alubsrc;
      logic [4:0]  aluctr;
      logic [2:0]  branch;
      logic        memtoreg;
      logic        memwr;
      logic [2:0]  memop;
      logic        jumps;
      logic        illegal;
   } dec_t;

   function automatic logic [31:0] imm_gen(
      input logic [31:0] i,
      input logic [2:0]  ext
   );
      logic [31:0] r;
      unique case (ext)
         EXT_I:   r = {{20{i[31]}}, i[31:20]};
         EXT_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
         EXT_B:   r = {{19{i[31]}}, i[31], i[7],
                       i[30:25], i[11:8], 1'b0};
         EXT_J:   r = {{11{i[31]}}, i[31], i[19:12],
                       i[20], i[30:21], 1'b0};
         EXT_U:   r = {i[31:12], 12'h000};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I instruction decoder: control, imm, illegal.
// Define RV32M_EN to decode func7=0000001 R-type as mul/div.
module decode_logic
   import decode_pkg::*;
(
   input  logic [31:0] inst,
   output dec_t        dec
);

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] alu_f3;
   logic       bad;
   dec_t       d;

   assign op = inst[6:0];
   assign f3 = inst[14:12];
   assign f7 = inst[31:25];

   // f7[5] separates sra/srl for both R and I shifts
   always_comb begin
      alu_f3 = ALU_ADD;
      unique case (f3)
         3'b000: alu_f3 = ALU_ADD;
         3'b001: alu_f3 = ALU_SLL;
         3'b010: alu_f3 = ALU_SLT;
         3'b011: alu_f3 = ALU_SLTU;
         3'b100: alu_f3 = ALU_XOR;
         3'b101: alu_f3 = f7[5] ? ALU_SRA : ALU_SRL;
         3'b110: alu_f3 = ALU_OR;
         3'b111: alu_f3 = ALU_AND;
      endcase
   end

   always_comb begin
      d     = '0;
      bad   = 1'b0;
      d.rs1 = inst[19:15];
      d.rs2 = inst[24:20];
      d.rd  = inst[11:7];
      unique case (1'b1)
         (inst[1:0] != 2'b11): bad = 1'b1;
         (op == OP_LUI): begin
            d.regwr   = 1'b1;
            d.alubsrc = BSRC_IMM;
            d.aluctr  = ALU_PASSB;
            d.extop   = EXT_U;
         end
         (op == OP_AUIPC): begin
            d.regwr   = 1'b1;
            d.aluasrc = 1'b1;
            d.alubsrc = BSRC_IMM;
            d.aluctr  = ALU_ADD;
            d.extop   = EXT_U;
         end
         (op == OP_JAL): begin
            d.regwr   = 1'b1;
            d.branch  = BR_JMP;
            d.jumps   = 1'b1;
            d.aluasrc = 1'b1;
            d.extop   = EXT_J;
         end
         (op == OP_JALR): begin
            d.regwr   = 1'b1;
            d.branch  = BR_JMP;
            d.alubsrc = BSRC_IMM;
            d.extop   = EXT_I;
            bad       = (f3 != 3'b000);
         end
         (op == OP_BRANCH): begin
            d.extop   = EXT_B;
            d.alubsrc = BSRC_RS2;
            d.aluctr  = ALU_SUB;
            unique case (f3)
               3'b000:  d.branch = BR_EQ;
               3'b001:  d.branch = BR_NE;
               3'b100:  d.branch = BR_LT;
               3'b101:  d.branch = BR_GE;
               3'b110:  d.branch = BR_LTU;
               3'b111:  d.branch = BR_GEU;
               default: bad = 1'b1;
            endcase
         end
         (op == OP_LOAD): begin
            d.regwr    = 1'b1;
            d.memtoreg = 1'b1;
            d.alubsrc  = BSRC_IMM;
            d.memop    = f3;
            bad = (f3 == 3'b011) || (f3 == 3'b110)
               || (f3 == 3'b111);
         end
         (op == OP_STORE): begin
            d.memwr   = 1'b1;
            d.alubsrc = BSRC_IMM;
            d.extop   = EXT_S;
            d.memop   = f3;
            bad       = (f3 > 3'b010);
         end
         (op == OP_IMM): begin
            d.regwr   = 1'b1;
            d.alubsrc = BSRC_IMM;
            d.extop   = EXT_I;
            d.aluctr  = alu_f3;
            bad = ((f3 == 3'b001) && (f7 != 7'b0000000))
               || ((f3 == 3'b101) && (f7 != 7'b0000000)
                   && (f7 != 7'b0100000));
         end
         (op == OP_REG): begin
            d.regwr   = 1'b1;
            d.alubsrc = BSRC_RS2;
            unique case (1'b1)
               (f7 == 7'b0000000): d.aluctr = alu_f3;
               (f7 == 7'b0100000): begin
                  d.aluctr = (f3 == 3'b000) ? ALU_SUB : alu_f3;
                  bad = (f3 != 3'b000) && (f3 != 3'b101);
               end
`ifdef RV32M_EN
               (f7 == 7'b0000001): d.aluctr = {2'b10, f3};
`endif
               default: bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
      d.imm     = imm_gen(inst, d.extop);
      d.illegal = bad;
      // illegal entries must not update any architectural state
      if (bad) begin
         d.regwr    = 1'b0;
         d.memwr    = 1'b0;
         d.memtoreg = 1'b0;
         d.branch   = BR_NONE;
      end
   end

   assign dec = d;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer.
// Build option RV32M_EN enables RV32M decode in decode_logic.
module decode_stage
   import decode_pkg::*;
#(
   parameter int PC_W     = 32,
   parameter int ALUCTR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [PC_W-1:0]     in_pc,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PC_W-1:0]     out_pc,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic [31:0]         out_imm,
   output logic [2:0]          ExtOp,
   output logic                RegWr,
   output logic                ALUASrc,
   output logic [1:0]          ALUBSrc,
   output logic [ALUCTR_W-1:0] ALUCtr,
   output logic [2:0]          Branch,
   output logic                MemtoReg,
   output logic                MemWr,
   output logic [2:0]          MemOp,
   output logic                JumpS,
   output logic                out_illegal
);

   skid_st_t        state;
   skid_st_t        state_nx;
   dec_t            dec;
   dec_t            o_dec;
   dec_t            s_dec;
   logic [PC_W-1:0] o_pc;
   logic [PC_W-1:0] s_pc;
   logic            acc;
   logic            drn;

   decode_logic u_dec (
      .inst (in_inst),
      .dec  (dec)
   );

   assign out_valid = (state != ST_EMPTY);
   assign acc = in_valid & in_ready & ~flush;
   assign drn = out_valid & out_ready;

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: if (acc) state_nx = ST_ONE;
            ST_ONE: begin
               if (acc && !drn) state_nx = ST_TWO;
               else if (!acc && drn) state_nx = ST_EMPTY;
            end
            ST_TWO: if (drn) state_nx = ST_ONE;
            default: state_nx = ST_EMPTY;
         endcase
      end
   end

   // in TWO in_ready is low, so acc implies EMPTY or ONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b1;
         o_dec    <= '0;
         s_dec    <= '0;
         o_pc     <= '0;
         s_pc     <= '0;
      end else begin
         state    <= state_nx;
         in_ready <= (state_nx != ST_TWO);
         if (!flush) begin
            if ((state == ST_TWO) && drn) begin
               o_dec <= s_dec;
               o_pc  <= s_pc;
            end else if (acc && ((state == ST_EMPTY) || drn)) begin
               o_dec <= dec;
               o_pc  <= in_pc;
            end else if (acc) begin
               s_dec <= dec;
               s_pc  <= in_pc;
            end
         end
      end
   end

   assign out_pc      = o_pc;
   assign out_rs1     = o_dec.rs1;
   assign out_rs2     = o_dec.rs2;
   assign out_rd      = o_dec.rd;
   assign out_imm     = o_dec.imm;
   assign ExtOp       = o_dec.extop;
   assign RegWr       = o_dec.regwr;
   assign ALUASrc     = o_dec.aluasrc;
   assign ALUBSrc     = o_dec.alubsrc;
   assign ALUCtr      = ALUCTR_W'(o_dec.aluctr);
   assign Branch      = o_dec.branch;
   assign MemtoReg    = o_dec.memtoreg;
   assign MemWr       = o_dec.memwr;
   assign MemOp       = o_dec.memop;
   assign JumpS       = o_dec.jumps;
   assign out_illegal = o_dec.illegal;

endmodule
